traffic_phase_timer: RTL and testbench
======================================

# traffic_phase_timer

Phase sequencer for the highway / country-road junction. It synchronises the country-road car sensor, runs the four-phase light state machine, and produces the phase counters `hwy_count` and `cr_count` that the downstream highway light driver decodes into highway LEDs. It also drives the country-road LEDs directly. It sits between the raw sensor input and the highway light driver.

## Interface
- `T`, default 10: highway green length in cycles. Highway green holds beyond this while no car is waiting. Legal range 1..15.
- `t`, default 3: yellow length in cycles, shared by both roads. Legal range 1..15.
- `TC`, default 5: maximum country green length in cycles. Legal range 1..15.
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sensor`, input, 1: raw asynchronous car-present signal from the country road.
- `sensor_sync`, output, 1: sensor after the 2-flop synchroniser. Forwarded to the downstream driver's `sensor` input.
- `hwy_count`, output, 4: highway phase counter.
- `cr_count`, output, 4: country phase counter.
- `country_led`, output, 3: country-road LEDs. 100 = green, 010 = yellow, 001 = red.
- `phase`, output, 2: current state. 00 = HG, 01 = HY, 10 = CG, 11 = CY.

## Operation
- Sensor synchroniser: two flops, `sensor` -> s1 -> `sensor_sync`. All FSM decisions use `sensor_sync` only.
- HG (highway green):
  - `cr_count` = 0.
  - `hwy_count` increments by 1 each cycle, saturating at T.
  - If `hwy_count`==T and `sensor_sync`==1: go to HY and load `hwy_count`<=t.
  - Otherwise stay in HG, holding `hwy_count` at T.
- HY (highway yellow):
  - `hwy_count` decrements each cycle.
  - When `hwy_count`==1: go to CG with `hwy_count`<=0 and `cr_count`<=1.
  - `sensor_sync` is ignored in HY.
- CG (country green):
  - `cr_count` increments each cycle.
  - If `cr_count`==TC or `sensor_sync`==0: go to CY and load `cr_count`<=t.
  - Early exit applies from the first CG cycle onward.
- CY (country yellow):
  - `cr_count` decrements each cycle.
  - When `cr_count`==1: go to HG with `hwy_count`<=1 and `cr_count`<=0.
- `country_led`: 100 in CG, 010 in CY, 001 in HG and HY. It is registered together with the state, so it never lags `phase`.
- Counters never wrap. Increments saturate at T or TC. Decrements never go below 1, because the exit condition is tested at 1.
- If T==t, the downstream decode is ambiguous. That is the integrator's responsibility; this block behaves as specified regardless.

## Timing
- Reset is applied on a rising edge with `rst`=1, and takes precedence over every transition, including mid-phase. Reset values:
  - `phase`=HG
  - `hwy_count`=0
  - `cr_count`=0
  - `country_led`=001
  - `sensor_sync`=0, s1=0
- First edge after reset release: `hwy_count`=1.
- Sensor latency: `sensor` to `sensor_sync` is 2 edges. A car arrival therefore reaches the FSM at least 2 cycles late. A pulse shorter than 1 clock may be lost; this is acceptable.
- Every transition takes effect on the edge where its condition is true. No idle cycles are inserted between phases.
- Full cycle with the sensor held at 1 is T + t + TC + t cycles: 10 + 3 + 5 + 3 = 21 with defaults.
- Simultaneous conditions in CG (`cr_count`==TC and `sensor_sync`==0): single transition to CY, `cr_count`<=t.

## Test plan
- Reset held for 3 edges, then released with `sensor`=0 → `hwy_count` reads 1, 2, …, 10 and then holds at 10 indefinitely. `phase`=00, `cr_count`=0, `country_led`=001 throughout.
- `sensor`=1 from reset release (edge 0) →
  - edge 11: `phase`=HY, `hwy_count`=3
  - edges 12–13: `hwy_count`=2, 1
  - edge 14: `phase`=CG, `cr_count`=1, `country_led`=100
  - edges 15–18: `cr_count`=2, 3, 4, 5
  - edge 19: `phase`=CY, `cr_count`=3, `country_led`=010
  - edges 20–21: `cr_count`=2, 1
  - edge 22: `phase`=HG, `hwy_count`=1, `cr_count`=0
- Sensor drops while in CG at `cr_count`=2 → 2 edges later `sensor_sync`=0; on the next edge `phase`=CY and `cr_count`=3, without reaching TC.
- Single-cycle sensor pulse → `sensor_sync` is high for exactly 1 cycle, 2 edges later. If `hwy_count`<T at that moment, there is no phase change.
- `rst` asserted during CY with `cr_count`=2 → on the next edge all outputs take their reset values, and the sequence restarts from `hwy_count`=1.
- Parameter override T=2, t=1, TC=1 with `sensor`=1 → phase sequence HG(1, 2), HY(1), CG(1), CY(1), HG(1), repeating with period 5 once `sensor_sync` is high.

Source files
------------

// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the car sensor, the phase sequencer and the highway light driver.
interface traffic_phase_timer_if;
  logic       sensor;
  logic       sensor_sync;
  logic [3:0] hwy_count;
  logic [3:0] cr_count;
  logic [2:0] country_led;
  logic [1:0] phase;

  // Environment side: supplies the raw sensor, observes the sequencer outputs.
  modport master (
    output sensor,
    input  sensor_sync,
    input  hwy_count,
    input  cr_count,
    input  country_led,
    input  phase
  );

  // Sequencer side.
  modport slave (
    input  sensor,
    output sensor_sync,
    output hwy_count,
    output cr_count,
    output country_led,
    output phase
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Four-phase highway / country-road light sequencer with sensor synchroniser
// and phase counters for the downstream highway light driver.
module traffic_phase_timer #(
  parameter int T  = 10,
  parameter int t  = 3,
  parameter int TC = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_phase_timer_if.slave  bus
);

  localparam logic [3:0] LP_T  = 4'(T);
  localparam logic [3:0] LP_Y  = 4'(t);
  localparam logic [3:0] LP_TC = 4'(TC);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    CG = 2'b10,
    CY = 2'b11
  } phase_t;

  logic       r_s1;
  logic       r_sync;
  phase_t     r_state;
  logic [3:0] r_hwy;
  logic [3:0] r_cr;
  logic [2:0] r_led;

  phase_t     w_state_nxt;
  logic [3:0] w_hwy_nxt;
  logic [3:0] w_cr_nxt;
  logic [2:0] w_led_nxt;

  // State, counters, LEDs and synchroniser registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_sync  <= 1'b0;
      r_state <= HG;
      r_hwy   <= '0;
      r_cr    <= '0;
      r_led   <= 3'b001;
    end else begin
      r_s1    <= bus.sensor;
      r_sync  <= r_s1;
      r_state <= w_state_nxt;
      r_hwy   <= w_hwy_nxt;
      r_cr    <= w_cr_nxt;
      r_led   <= w_led_nxt;
    end
  end

  // Next phase and next counter values; every transition loads its counters on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_hwy_nxt   = r_hwy;
    w_cr_nxt    = r_cr;
    case (r_state)
      HG: begin
        w_cr_nxt = '0;
        if (r_hwy == LP_T) begin
          if (r_sync) begin
            w_state_nxt = HY;
            w_hwy_nxt   = LP_Y;
          end
        end else begin
          w_hwy_nxt = r_hwy + 4'd1;
        end
      end
      HY: begin
        if (r_hwy == 4'd1) begin
          w_state_nxt = CG;
          w_hwy_nxt   = '0;
          w_cr_nxt    = 4'd1;
        end else begin
          w_hwy_nxt = r_hwy - 4'd1;
        end
      end
      CG: begin
        if ((r_cr == LP_TC) || !r_sync) begin
          w_state_nxt = CY;
          w_cr_nxt    = LP_Y;
        end else begin
          w_cr_nxt = r_cr + 4'd1;
        end
      end
      CY: begin
        if (r_cr == 4'd1) begin
          w_state_nxt = HG;
          w_hwy_nxt   = 4'd1;
          w_cr_nxt    = '0;
        end else begin
          w_cr_nxt = r_cr - 4'd1;
        end
      end
      default: begin
        w_state_nxt = HG;
        w_hwy_nxt   = '0;
        w_cr_nxt    = '0;
      end
    endcase
  end

  // Country LEDs decoded from the next phase so the registered LEDs never lag the phase.
  always_comb begin
    w_led_nxt = 3'b001;
    case (w_state_nxt)
      CG:      w_led_nxt = 3'b100;
      CY:      w_led_nxt = 3'b010;
      default: w_led_nxt = 3'b001;
    endcase
  end

  assign bus.sensor_sync = r_sync;
  assign bus.hwy_count   = r_hwy;
  assign bus.cr_count    = r_cr;
  assign bus.country_led = r_led;
  assign bus.phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed self-checking bench for traffic_phase_timer (default and minimal parameter sets).
module tb_traffic_phase_timer;

  logic clk;
  logic rst;

  traffic_phase_timer_if u_if ();
  traffic_phase_timer_if u_if2 ();

  traffic_phase_timer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  traffic_phase_timer #(
    .T  (2),
    .t  (1),
    .TC (1)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int led_of(input int ph);
    if (ph == 2) return 4;
    if (ph == 3) return 2;
    return 1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_phase"}, int'(u_if.phase), 0);
    check_eq({tag, "_hwy"},   int'(u_if.hwy_count), 0);
    check_eq({tag, "_cr"},    int'(u_if.cr_count), 0);
    check_eq({tag, "_led"},   int'(u_if.country_led), 1);
    check_eq({tag, "_sync"},  int'(u_if.sensor_sync), 0);
  endtask

  // Tick until the default instance is in CG with the given cr_count, within a cycle budget.
  task automatic wait_cg(input string tag, input int cr_target, input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (u_if.phase == 2'b10 && int'(u_if.cr_count) == cr_target) begin
        found = 1;
        break;
      end
    end
    check_eq({tag, "_reached"}, found, 1);
  endtask

  initial begin
    int e_ph [22] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,2,2,2,2,2,3,3,3,0};
    int e_hw [22] = '{1,2,3,4,5,6,7,8,9,10,3,2,1,0,0,0,0,0,0,0,0,1};
    int e_cr [22] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,2,3,4,5,3,2,1,0};
    int m_ph [12] = '{0,0,1,2,3,0,0,1,2,3,0,0};
    int m_hw [12] = '{1,2,1,0,0,1,2,1,0,0,1,2};
    int m_cr [12] = '{0,0,0,1,1,0,0,0,1,1,0,0};

    rst = 1'b1;
    u_if.sensor  = 1'b0;
    u_if2.sensor = 1'b1;

    // Reset held for 3 edges.
    repeat (3) tick();
    check_reset_vals("rst");

    // Release with no car: count up to T and hold.
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check_eq($sformatf("idle_hwy_e%0d", i), int'(u_if.hwy_count), (i < 10) ? i : 10);
      check_eq($sformatf("idle_ph_e%0d", i),  int'(u_if.phase), 0);
      check_eq($sformatf("idle_cr_e%0d", i),  int'(u_if.cr_count), 0);
      check_eq($sformatf("idle_led_e%0d", i), int'(u_if.country_led), 1);
    end

    // Full cycle with the car present from release.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    u_if.sensor = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      check_eq($sformatf("cyc_ph_e%0d", i),  int'(u_if.phase), e_ph[i-1]);
      check_eq($sformatf("cyc_hwy_e%0d", i), int'(u_if.hwy_count), e_hw[i-1]);
      check_eq($sformatf("cyc_cr_e%0d", i),  int'(u_if.cr_count), e_cr[i-1]);
      check_eq($sformatf("cyc_led_e%0d", i), int'(u_if.country_led), led_of(e_ph[i-1]));
      check_eq($sformatf("cyc_sync_e%0d", i), int'(u_if.sensor_sync), (i >= 2) ? 1 : 0);
    end

    // Car leaves during CG at cr_count=2: early exit to CY before TC.
    wait_cg("drop", 2, 40);
    u_if.sensor = 1'b0;
    tick();
    check_eq("drop_cr_a", int'(u_if.cr_count), 3);
    check_eq("drop_sync_a", int'(u_if.sensor_sync), 1);
    tick();
    check_eq("drop_sync_b", int'(u_if.sensor_sync), 0);
    check_eq("drop_cr_b", int'(u_if.cr_count), 4);
    check_eq("drop_ph_b", int'(u_if.phase), 2);
    tick();
    check_eq("drop_ph_c", int'(u_if.phase), 3);
    check_eq("drop_cr_c", int'(u_if.cr_count), 3);
    check_eq("drop_led_c", int'(u_if.country_led), 2);
    tick();
    check_eq("cy_cr_2", int'(u_if.cr_count), 2);

    // Reset mid-CY.
    rst = 1'b1;
    u_if.sensor = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    u_if.sensor = 1'b0;
    tick();
    check_eq("restart_hwy_1", int'(u_if.hwy_count), 1);
    tick();
    check_eq("restart_hwy_2", int'(u_if.hwy_count), 2);

    // Single-cycle pulse while hwy_count < T.
    u_if.sensor = 1'b1;
    tick();
    u_if.sensor = 1'b0;
    check_eq("pulse_sync_0", int'(u_if.sensor_sync), 0);
    tick();
    check_eq("pulse_sync_1", int'(u_if.sensor_sync), 1);
    check_eq("pulse_hwy_1", int'(u_if.hwy_count), 4);
    tick();
    check_eq("pulse_sync_2", int'(u_if.sensor_sync), 0);
    check_eq("pulse_ph_2", int'(u_if.phase), 0);
    tick();
    check_eq("pulse_ph_3", int'(u_if.phase), 0);
    check_eq("pulse_hwy_3", int'(u_if.hwy_count), 6);

    // Sensor drop lands exactly as cr_count reaches TC: single transition to CY.
    u_if.sensor = 1'b1;
    wait_cg("simul", 3, 40);
    u_if.sensor = 1'b0;
    tick();
    check_eq("simul_cr_4", int'(u_if.cr_count), 4);
    tick();
    check_eq("simul_cr_5", int'(u_if.cr_count), 5);
    check_eq("simul_sync", int'(u_if.sensor_sync), 0);
    tick();
    check_eq("simul_ph", int'(u_if.phase), 3);
    check_eq("simul_cr", int'(u_if.cr_count), 3);

    // Minimal parameter set: period-5 sequence.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq($sformatf("min_ph_e%0d", i),  int'(u_if2.phase), m_ph[i-1]);
      check_eq($sformatf("min_hwy_e%0d", i), int'(u_if2.hwy_count), m_hw[i-1]);
      check_eq($sformatf("min_cr_e%0d", i),  int'(u_if2.cr_count), m_cr[i-1]);
      check_eq($sformatf("min_led_e%0d", i), int'(u_if2.country_led), led_of(m_ph[i-1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
